layer_sequencer: RTL and testbench
==================================

Name: layer_sequencer

Overview:
Top-level scheduler for the 1D-CNN inference chain: conv1d, maxpool1d and dense stages. Those stages have no start input; each begins computing when its rstn is released and raises a level `done` when finished. This block owns one active-low reset per stage and releases the stages in order, each after the previous stage reports done. It also runs a per-stage watchdog, reports completion or fault, and keeps finished stages out of reset so their output registers hold their results.

Parameters:
- NUM_STAGES, 4: number of sequenced stages; stage 0 runs first.
- TIMEOUT_W, 20: width of the watchdog counter.
- TIMEOUT_CYCLES, 1000000: cycles allowed per stage before a fault. 0 disables the watchdog. Must be less than 2^TIMEOUT_W.
- STG_W, $clog2(NUM_STAGES) with a minimum of 1: width of stage indices.

Ports:
- clk, in, 1: clock.
- rstn, in, 1: synchronous, active-low reset.
- start, in, 1: begin an inference run; sampled only in IDLE.
- abort, in, 1: cancel the run in progress.
- stage_done, in, NUM_STAGES: level done flags from the stages; bit k comes from stage k.
- stage_rstn, out, NUM_STAGES: registered active-low per-stage resets.
- busy, out, 1: high from the cycle after start is accepted until completion, fault or abort.
- done, out, 1: single-cycle pulse when the last stage completes.
- error, out, 1: sticky watchdog fault flag.
- cur_stage, out, STG_W: index of the stage currently running.
- err_stage, out, STG_W: stage that timed out; valid while error=1.

Behaviour:
- Reset (rstn=0 at a clk edge):
  - state=IDLE, stage_rstn=all 0, busy=0, done=0, error=0, cur_stage=0, err_stage=0, watchdog=0.
  - Applies in any state, mid-run included.
- States: IDLE, CLEAR, RUN, COMPLETE, FAULT. All outputs are registered.
- IDLE:
  - stage_rstn keeps its last value: all 1 after a successful run, all 0 after reset, fault or abort.
  - start=1 moves to CLEAR. The error flag clears in the same cycle.
- CLEAR (exactly 1 cycle):
  - stage_rstn=all 0, busy=1, cur_stage=0, watchdog=0.
  - Next state is RUN, with stage_rstn[0]=1 registered on entry.
  - Every run therefore forces at least one reset cycle into every stage, which clears any stale done.
- RUN:
  - stage_rstn[k]=1 for all k <= cur_stage; all other bits are 0. The watchdog increments every cycle.
  - If stage_done[cur_stage]=1 and cur_stage < NUM_STAGES-1: cur_stage increments, stage_rstn[cur_stage+1] is set, the watchdog clears, and the state stays RUN.
  - If stage_done[cur_stage]=1 and cur_stage = NUM_STAGES-1: go to COMPLETE.
  - Else if TIMEOUT_CYCLES≠0 and watchdog = TIMEOUT_CYCLES-1: go to FAULT.
  - done of the current stage wins over timeout when both occur in the same cycle.
  - stage_done bits for stages other than cur_stage are ignored.
- Latency:
  - The start edge is followed by 1 CLEAR cycle, then stage 0 is released.
  - Stage k+1 is released on the edge after stage k's done is sampled high.
  - The done pulse appears 1 cycle after the last stage's done is sampled.
- COMPLETE (1 cycle): done=1 and busy=0. stage_rstn stays all 1 so results remain visible. Next state is IDLE.
- FAULT (1 cycle):
  - error=1, err_stage=cur_stage, stage_rstn=all 0, busy=0, done=0.
  - Next state is IDLE. error stays high until the next accepted start or reset.
- abort=1 in CLEAR or RUN:
  - Next state is IDLE with stage_rstn=all 0, busy=0, cur_stage=0.
  - No done pulse; error is unchanged.
  - abort has priority over stage_done and timeout in the same cycle. abort in IDLE has no effect.
- start while busy=1 is ignored. start and abort together in IDLE: start is accepted.
- Watchdog width: the counter saturates logic-free because the fault fires at TIMEOUT_CYCLES-1; the counter never wraps.

Decomposition:
- Package nn_ctrl_pkg holds:
  - the seq_state_t enum (IDLE, CLEAR, RUN, COMPLETE, FAULT);
  - the default timeout constant;
  - the STG_W helper function.
- One natural sub-module: stage_watchdog, with clear/enable inputs and an expired output at TIMEOUT_CYCLES-1, and 0 meaning disabled.
- Everything else stays in layer_sequencer.

Test Plan:
All scenarios use NUM_STAGES=3 and TIMEOUT_CYCLES=16.
1. Normal run. Start at cycle 0; each stage model raises done 5 cycles after its rstn rises.
   - stage_rstn goes 000 at cycle 1, then 001, 011, 111.
   - done pulses for exactly 1 cycle; busy falls with it; stage_rstn stays 111 in IDLE.
2. Stage 1 never asserts done.
   - 16 cycles after stage 1 is released: error=1, err_stage=1, stage_rstn=000, no done pulse.
   - A following start clears error.
3. stage_done[2] forced high while cur_stage=0, and a start pulse mid-run.
   - Both are ignored: no skip, no restart, normal completion.
4. abort asserted during stage 1 in the same cycle as stage_done[1].
   - Next cycle: IDLE, stage_rstn=000, busy=0, no done, error=0.
5. Stage 0 done asserted exactly at watchdog count 15.
   - Advances to stage 1 with no fault.
   - Run a second start after a successful run: one 000 cycle precedes 001.
6. rstn pulled low for 1 cycle during stage 2.
   - All outputs return to their reset values; no done pulse.

Source files
------------

// File: rtl/nn_ctrl_pkg.sv
// Shared types and constants for the CNN stage sequencer.
package nn_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    COMPLETE,
    FAULT
  } seq_state_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 1000000;

  // Stage index width, never narrower than one bit.
  function automatic int stg_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage cycle counter; expired_o is high while the count sits at TIMEOUT_CYCLES-1.
// TIMEOUT_CYCLES=0 keeps expired_o low forever.
module stage_watchdog #(
  parameter int TIMEOUT_W      = 20,
  parameter int TIMEOUT_CYCLES = nn_ctrl_pkg::DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TIMEOUT_W-1:0] LIMIT =
    (TIMEOUT_CYCLES == 0) ? '0 : TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_W-1:0] count_q, count_d;

  // No saturation needed: the sequencer leaves RUN on the expiring cycle.
  always_comb begin
    count_d = count_q;
    if (clr_i)     count_d = '0;
    else if (en_i) count_d = count_q + TIMEOUT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) count_q <= '0;
    else       count_q <= count_d;
  end

  assign expired_o = (TIMEOUT_CYCLES != 0) && (count_q == LIMIT);

endmodule

// File: rtl/layer_sequencer.sv
// Releases stage resets in order as each stage reports done, with a per-stage watchdog.
// All outputs registered; finished stages stay out of reset so their results hold.
module layer_sequencer
  import nn_ctrl_pkg::*;
#(
  parameter int NUM_STAGES     = 4,
  parameter int TIMEOUT_W      = 20,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int STG_W          = stg_width(NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [NUM_STAGES-1:0] stage_rstn,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [STG_W-1:0]      cur_stage,
  output logic [STG_W-1:0]      err_stage
);

  localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(NUM_STAGES - 1);

  seq_state_t            state_q, state_d;
  logic [NUM_STAGES-1:0] stage_rstn_q, stage_rstn_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [STG_W-1:0]      cur_stage_q, cur_stage_d;
  logic [STG_W-1:0]      err_stage_q, err_stage_d;
  logic [STG_W-1:0]      nxt_stage;
  logic                  wd_clr, wd_expired;

  stage_watchdog #(
    .TIMEOUT_W      (TIMEOUT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rstn      (rstn),
    .clr_i     (wd_clr),
    .en_i      (state_q == RUN),
    .expired_o (wd_expired)
  );

  assign nxt_stage = cur_stage_q + STG_W'(1);

  always_comb begin
    state_d      = state_q;
    stage_rstn_d = stage_rstn_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    error_d      = error_q;
    cur_stage_d  = cur_stage_q;
    err_stage_d  = err_stage_q;
    wd_clr       = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = CLEAR;
          stage_rstn_d = '0;
          busy_d       = 1'b1;
          error_d      = 1'b0;
          cur_stage_d  = '0;
        end
      end
      CLEAR: begin
        if (abort) begin
          state_d      = IDLE;
          stage_rstn_d = '0;
          busy_d       = 1'b0;
          cur_stage_d  = '0;
        end else begin
          state_d      = RUN;
          stage_rstn_d = NUM_STAGES'(1);
        end
      end
      RUN: begin
        // Priority: abort, then current stage done, then timeout.
        if (abort) begin
          state_d      = IDLE;
          stage_rstn_d = '0;
          busy_d       = 1'b0;
          cur_stage_d  = '0;
        end else if (stage_done[cur_stage_q]) begin
          if (cur_stage_q == LAST_STAGE) begin
            state_d = COMPLETE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            cur_stage_d             = nxt_stage;
            stage_rstn_d[nxt_stage] = 1'b1;
          end
        end else if (wd_expired) begin
          state_d      = FAULT;
          error_d      = 1'b1;
          err_stage_d  = cur_stage_q;
          stage_rstn_d = '0;
          busy_d       = 1'b0;
        end else begin
          wd_clr = 1'b0;
        end
      end
      COMPLETE: state_d = IDLE;
      FAULT:    state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      stage_rstn_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      cur_stage_q  <= '0;
      err_stage_q  <= '0;
    end else begin
      state_q      <= state_d;
      stage_rstn_q <= stage_rstn_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      cur_stage_q  <= cur_stage_d;
      err_stage_q  <= err_stage_d;
    end
  end

  assign stage_rstn = stage_rstn_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign cur_stage  = cur_stage_q;
  assign err_stage  = err_stage_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed and randomized checks of layer_sequencer against a run-level reference model.
module tb_layer_sequencer;

  localparam int N = 3;
  localparam int T = 16;

  logic         clk = 1'b0;
  logic         rstn, start, abort;
  logic [N-1:0] stage_done;
  logic [N-1:0] stage_rstn;
  logic         busy, done, error;
  logic [1:0]   cur_stage, err_stage;

  always #5 clk = ~clk;

  layer_sequencer #(
    .NUM_STAGES     (N),
    .TIMEOUT_W      (20),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .abort      (abort),
    .stage_done (stage_done),
    .stage_rstn (stage_rstn),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .cur_stage  (cur_stage),
    .err_stage  (err_stage)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Stage environment: stage k raises done lat[k] cycles after its reset lifts (lat<=0: never).
  int           lat [N];
  int           cnt [N];
  logic [N-1:0] env_done;
  logic [N-1:0] noise;

  // Reference model: a run is active from start acceptance; m_stage=-1 is the forced-reset cycle.
  bit           m_active, m_cool;
  int           m_stage, m_el;
  logic [N-1:0] e_rstn;
  logic         e_busy, e_done, e_err;
  int           e_cur, e_errs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic s, input logic a, input logic [N-1:0] sd);
    if (!r) begin
      m_active = 0; m_cool = 0; m_stage = 0; m_el = 0;
      e_rstn = '0; e_busy = 0; e_done = 0; e_err = 0; e_cur = 0; e_errs = 0;
    end else begin
      e_done = 0;
      if (m_cool) begin
        m_cool = 0;
      end else if (!m_active) begin
        if (s) begin
          m_active = 1; m_stage = -1; m_el = 0;
          e_rstn = '0; e_busy = 1; e_err = 0; e_cur = 0;
        end
      end else if (a) begin
        m_active = 0; e_rstn = '0; e_busy = 0; e_cur = 0;
      end else if (m_stage < 0) begin
        m_stage = 0; m_el = 0; e_rstn = N'(1);
      end else if (sd[m_stage]) begin
        if (m_stage == N - 1) begin
          e_done = 1; e_busy = 0; m_active = 0; m_cool = 1;
        end else begin
          m_stage++; m_el = 0;
          e_rstn = N'((1 << (m_stage + 1)) - 1);
          e_cur  = m_stage;
        end
      end else if (m_el == T - 1) begin
        e_err = 1; e_errs = m_stage; e_rstn = '0; e_busy = 0; m_active = 0; m_cool = 1;
      end else begin
        m_el++;
      end
    end
  endtask

  task automatic step(input logic r, input logic s, input logic a);
    rstn = r; start = s; abort = a;
    stage_done = env_done | noise;
    @(posedge clk);
    model_step(r, s, a, stage_done);
    #1;
    chk("stage_rstn", {{(32-N){1'b0}}, stage_rstn}, {{(32-N){1'b0}}, e_rstn});
    chk("busy",       {31'b0, busy},  {31'b0, e_busy});
    chk("done",       {31'b0, done},  {31'b0, e_done});
    chk("error",      {31'b0, error}, {31'b0, e_err});
    chk("cur_stage",  {30'b0, cur_stage}, 32'(e_cur));
    if (e_err) chk("err_stage", {30'b0, err_stage}, 32'(e_errs));
    for (int k = 0; k < N; k++) begin
      if (!stage_rstn[k]) cnt[k] = 0;
      else                cnt[k]++;
      env_done[k] = (lat[k] > 0) && (cnt[k] >= lat[k]);
    end
  endtask

  task automatic set_lat(input int l0, input int l1, input int l2);
    lat[0] = l0; lat[1] = l1; lat[2] = l2;
  endtask

  initial begin
    bit hit;
    rstn = 1'b0; start = 1'b0; abort = 1'b0; stage_done = '0;
    env_done = '0; noise = '0;
    for (int k = 0; k < N; k++) cnt[k] = 0;
    set_lat(5, 5, 5);

    // Reset state
    step(0, 0, 0);
    step(0, 1, 1);
    chk("reset_rstn", {29'b0, stage_rstn}, 32'd0);

    // 1: normal run, all stages finish after 5 cycles
    step(1, 1, 0);
    repeat (30) step(1, 0, 0);
    chk("s1_rstn_hold", {29'b0, stage_rstn}, 32'd7);

    // 2: stage 1 hangs -> watchdog fault, then a new start clears error
    set_lat(5, 0, 5);
    step(1, 1, 0);
    repeat (35) step(1, 0, 0);
    chk("s2_error", {31'b0, error}, 32'd1);
    chk("s2_err_stage", {30'b0, err_stage}, 32'd1);
    set_lat(5, 5, 5);
    step(1, 1, 0);
    chk("s2_error_clr", {31'b0, error}, 32'd0);
    repeat (25) step(1, 0, 0);

    // 3: stale done on stage 2 during stage 0 and a mid-run start are ignored
    step(1, 1, 0);
    noise = 3'b100;
    step(1, 0, 0);
    step(1, 1, 0);
    step(1, 0, 0);
    noise = '0;
    repeat (25) step(1, 0, 0);

    // 4: abort coinciding with stage 1 done
    set_lat(3, 4, 5);
    step(1, 1, 0);
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (env_done[1] && cur_stage == 2'd1) begin
        step(1, 0, 1);
        hit = 1;
        chk("s4_busy", {31'b0, busy}, 32'd0);
        chk("s4_rstn", {29'b0, stage_rstn}, 32'd0);
        chk("s4_done", {31'b0, done}, 32'd0);
      end else begin
        step(1, 0, 0);
      end
    end
    chk("s4_abort_reached", {31'b0, hit}, 32'd1);
    repeat (5) step(1, 0, 0);

    // 5: stage 0 done at the last watchdog count, then one cycle too late
    set_lat(16, 5, 5);
    step(1, 1, 0);
    repeat (40) step(1, 0, 0);
    chk("s5_no_fault", {31'b0, error}, 32'd0);
    step(1, 1, 0);
    chk("s5_clear_cycle", {29'b0, stage_rstn}, 32'd0);
    step(1, 0, 0);
    chk("s5_release0", {29'b0, stage_rstn}, 32'd1);
    repeat (40) step(1, 0, 0);
    set_lat(17, 5, 5);
    step(1, 1, 0);
    repeat (25) step(1, 0, 0);
    chk("s5_late_fault", {31'b0, error}, 32'd1);
    chk("s5_late_stage", {30'b0, err_stage}, 32'd0);

    // 6: reset pulse during stage 2
    set_lat(5, 5, 5);
    step(1, 1, 0);
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step(1, 0, 0);
      if (cur_stage == 2'd2) hit = 1;
    end
    chk("s6_stage2_reached", {31'b0, hit}, 32'd1);
    step(0, 0, 0);
    chk("s6_rst_rstn", {29'b0, stage_rstn}, 32'd0);
    chk("s6_rst_busy", {31'b0, busy}, 32'd0);
    repeat (10) step(1, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0)
        set_lat($urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 20));
      noise = ($urandom_range(0, 9) == 0) ? N'($urandom_range(0, 7)) : '0;
      step($urandom_range(0, 99) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
